// File: rtl/arb_pkg.sv
// Shared types and the rotating-priority search used by the round-robin
// grant controller.
package arb_pkg;

  localparam int NUM_REQ = 16;
  localparam int IDX_W   = 4;

  typedef logic [NUM_REQ-1:0] req_vec_t;
  typedef logic [IDX_W-1:0]   idx_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic valid;
    idx_t idx;
  } pick_t;

  // Offsets are scanned from the far end toward ptr, so the closest set bit wins.
  function automatic pick_t first_set_from(input req_vec_t req, input idx_t ptr);
    pick_t res;
    idx_t  cand;
    res.valid = 1'b0;
    res.idx   = ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = ptr + idx_t'(k);
      if (req[cand]) begin
        res.valid = 1'b1;
        res.idx   = cand;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/decoder_4_16.sv
// 4-to-16 one-hot decoder with enable; output is all-zero when disabled.
module decoder_4_16
  import arb_pkg::*;
(
  input  logic [3:0]  idx,
  input  logic        en,
  output logic [15:0] onehot
);

  // One-hot expansion of idx, gated by en.
  always_comb begin
    onehot = 16'h0000;
    if (en) begin
      onehot[idx] = 1'b1;
    end else begin
      onehot = 16'h0000;
    end
  end

endmodule

// File: rtl/rr_grant_ctrl_16.sv
// Round-robin arbiter for 16 requesters sharing one select resource, with a
// hold timeout that preempts a long grant only when someone else is waiting.
module rr_grant_ctrl_16
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [15:0] req,
  output logic [15:0] grant,
  output logic [3:0]  grant_idx,
  output logic        grant_valid,
  output logic        preempt
);

  localparam bit               HOLD_EN   = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? {CNT_W{1'b0}} : CNT_W'(MAX_HOLD - 1);

  arb_state_t       state_q, state_d;
  idx_t             ptr_q, ptr_d;
  idx_t             idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             preempt_q, preempt_d;
  logic             grant_valid_s;
  logic             others_s;
  pick_t            pick_s;
  req_vec_t         grant_s;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= 4'h0;
      idx_q     <= 4'h0;
      cnt_q     <= {CNT_W{1'b0}};
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      preempt_q <= preempt_d;
    end
  end

  // Next-state: grant the rotating winner, release on drop or on timeout.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    preempt_d = 1'b0;
    pick_s    = first_set_from(req, ptr_q);
    others_s  = |(req & ~grant_s);
    case (state_q)
      IDLE: begin
        if (enable && pick_s.valid) begin
          state_d = BUSY;
          idx_d   = pick_s.idx;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        // A dropped request wins over a simultaneous timeout: no preempt pulse.
        if (!req[idx_q]) begin
          state_d = IDLE;
          ptr_d   = idx_q + 4'h1;
          cnt_d   = {CNT_W{1'b0}};
        end else if (HOLD_EN && (cnt_q >= HOLD_LAST) && others_s) begin
          state_d   = IDLE;
          ptr_d     = idx_q + 4'h1;
          cnt_d     = {CNT_W{1'b0}};
          preempt_d = 1'b1;
        end else if (cnt_q < HOLD_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs derive only from registers.
  always_comb begin
    grant_valid_s = (state_q == BUSY);
  end

  decoder_4_16 u_dec (
    .idx    (idx_q),
    .en     (grant_valid_s),
    .onehot (grant_s)
  );

  assign grant       = grant_s;
  assign grant_idx   = idx_q;
  assign grant_valid = grant_valid_s;
  assign preempt     = preempt_q;

endmodule

// File: tb/tb_rr_grant_ctrl_16.sv
// Scoreboard bench for rr_grant_ctrl_16: a behavioural model predicts each
// cycle's outputs into a queue; a monitor pops and compares on the falling edge.
module tb_rr_grant_ctrl_16;

  localparam int MAX_HOLD = 8;

  typedef struct {
    logic [15:0] grant;
    logic [3:0]  idx;
    logic        valid;
    logic        pre;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] req = 16'h0000;
  logic [15:0] grant;
  logic [3:0]  grant_idx;
  logic        grant_valid;
  logic        preempt;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];

  // Model state: owner is -1 when nobody holds the resource.
  int m_owner = -1;
  int m_held  = 0;
  int m_ptr   = 0;
  int m_last  = 0;
  bit m_pre   = 1'b0;

  rr_grant_ctrl_16 #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .req         (req),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .preempt     (preempt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, want, $time);
    end
  endtask

  // Reference model: applies the arbitration rules once per clock.
  always @(posedge clk or negedge rst_n) begin
    exp_t e;
    bit   others;
    if (!rst_n) begin
      m_owner = -1; m_held = 0; m_ptr = 0; m_last = 0; m_pre = 1'b0;
      exp_q.delete();
    end else begin
      if (m_owner < 0) begin
        m_pre = 1'b0;
        if (enable && req != 16'h0000) begin
          for (int off = 0; off < 16; off++) begin
            if (m_owner < 0 && req[(m_ptr + off) % 16]) begin
              m_owner = (m_ptr + off) % 16;
              m_last  = m_owner;
              m_held  = 1;
            end
          end
        end
      end else begin
        others = (req & ~(16'h0001 << m_owner)) != 16'h0000;
        if (!req[m_owner]) begin
          m_ptr = (m_owner + 1) % 16; m_owner = -1; m_pre = 1'b0;
        end else if (MAX_HOLD != 0 && m_held >= MAX_HOLD && others) begin
          m_ptr = (m_owner + 1) % 16; m_owner = -1; m_pre = 1'b1;
        end else begin
          m_held++; m_pre = 1'b0;
        end
      end
      e.valid = (m_owner >= 0);
      e.grant = e.valid ? (16'h0001 << m_owner) : 16'h0000;
      e.idx   = 4'(m_last);
      e.pre   = m_pre;
      exp_q.push_back(e);
    end
  end

  // Monitor: compare DUT outputs with the oldest prediction.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("grant", {16'h0, grant}, {16'h0, e.grant});
      chk("grant_idx", {28'h0, grant_idx}, {28'h0, e.idx});
      chk("grant_valid", {31'h0, grant_valid}, {31'h0, e.valid});
      chk("preempt", {31'h0, preempt}, {31'h0, e.pre});
    end
  end

  task automatic drive(input logic e, input logic [15:0] r, input int n);
    enable = e;
    req    = r;
    repeat (n) @(negedge clk);
  endtask

  task automatic async_reset_check(input string tag);
    #3;
    rst_n = 1'b0;
    #1;
    chk({tag, "_rst_grant"}, {16'h0, grant}, 32'h0);
    chk({tag, "_rst_valid"}, {31'h0, grant_valid}, 32'h0);
    chk({tag, "_rst_idx"}, {28'h0, grant_idx}, 32'h0);
    chk({tag, "_rst_preempt"}, {31'h0, preempt}, 32'h0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] rr;
    #2;
    chk("reset_grant", {16'h0, grant}, 32'h0);
    chk("reset_valid", {31'h0, grant_valid}, 32'h0);
    chk("reset_idx", {28'h0, grant_idx}, 32'h0);
    chk("reset_preempt", {31'h0, preempt}, 32'h0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);

    drive(1'b1, 16'h0001, 3);
    drive(1'b1, 16'h0000, 2);
    drive(1'b1, 16'h8001, 3);
    drive(1'b1, 16'h8000, 4);
    drive(1'b1, 16'h0001, 4);
    drive(1'b1, 16'h0000, 2);
    drive(1'b1, 16'h0020, 3);
    drive(1'b1, 16'h0220, 12);
    drive(1'b1, 16'h0200, 3);
    drive(1'b1, 16'h0000, 2);
    drive(1'b1, 16'h0008, 40);
    drive(1'b1, 16'h0000, 2);

    drive(1'b1, 16'h0040, 3);
    async_reset_check("mid_grant");
    drive(1'b1, 16'h0010, 3);
    drive(1'b1, 16'h0000, 2);

    async_reset_check("pre_enable");
    drive(1'b0, 16'hFFFF, 4);
    drive(1'b1, 16'hFFFF, 1);
    drive(1'b0, 16'hFFFF, 4);
    drive(1'b0, 16'hFFFE, 3);
    drive(1'b1, 16'h0000, 2);

    rr = 16'h0000;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int b = 0; b < 16; b++) begin
        if ($urandom_range(0, 7) == 0) rr[b] = ~rr[b];
      end
      drive(($urandom_range(0, 9) != 0), rr, 1);
      if ($urandom_range(0, 399) == 0) async_reset_check("random");
    end

    drive(1'b1, 16'h0000, 3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_grant_ctrl_16.md
Name: rr_grant_ctrl_16

Overview:
- Round-robin arbiter that shares one 4-to-16 one-hot select resource among 16 requesters.
- Picks one requester, registers its 4-bit index, and drives a one-hot grant vector through an internal 4-to-16 decoder.
- Holds the grant until the requester releases it, or until a hold timeout preempts it while others are waiting.
- Sits between request sources and the shared select/bus-enable datapath.

Parameters:
- MAX_HOLD, default 8: maximum grant cycles before preemption when other requests are pending; 0 disables preemption.
- CNT_W, default 4: hold counter width; must satisfy 2**CNT_W > MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- enable  input  1  permits new grants; an existing grant is unaffected
- req  input  16  request vector, bit i = requester i
- grant  output  16  registered-path one-hot grant; all-zero when no grant (never z or x)
- grant_idx  output  4  index of the current or last granted requester
- grant_valid  output  1  a grant is active
- preempt  output  1  one-cycle pulse marking a timeout-forced release

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE
  - grant_valid=0, grant=16'h0000, grant_idx=4'h0, preempt=0
  - priority pointer ptr=4'h0, hold counter cnt=0
- States:
  - IDLE: no grant.
  - BUSY: grant_valid=1, grant = one-hot(grant_idx).
- IDLE -> BUSY:
  - Taken when enable=1 and req!=0.
  - Winner = first set bit of req scanning ptr, ptr+1, ..., wrapping 15 -> 0.
  - grant_idx, grant_valid and grant update on the next edge (1-cycle latency); cnt=0.
- BUSY hold:
  - Stays in BUSY while req[grant_idx]=1 and no preemption occurs.
  - cnt increments each BUSY cycle and saturates at MAX_HOLD.
- BUSY -> IDLE, release:
  - req[grant_idx]=0 sampled -> grant_valid=0 and grant=0 at the next edge; ptr=grant_idx+1 (mod 16).
- BUSY -> IDLE, preemption:
  - Condition: MAX_HOLD!=0, cnt==MAX_HOLD-1, and (req & ~grant)!=0.
  - Release occurs at the next edge; preempt=1 for exactly that one cycle; ptr=grant_idx+1.
- Simultaneous release and preemption: treat as release; preempt=0.
- No other requesters at timeout: the grant is kept and cnt saturates; preemption fires on the first later cycle in which another req bit is set.
- Handover: at least one IDLE cycle between consecutive grants, so grant is never nonzero for two different indices on adjacent cycles.
- enable=0 in IDLE: stay in IDLE; ptr is unchanged.
- grant_idx holds its last value while IDLE; only grant_valid qualifies it.
- grant is zero whenever grant_valid=0; the decoder is enabled by grant_valid and outputs 0 when disabled.
- Async reset mid-grant: all outputs return to reset values immediately; ptr returns to 0.
- Invariant: $onehot0(grant), and grant_valid == (grant!=0).

Decomposition:
- Shared package arb_pkg:
  - NUM_REQ=16, IDX_W=4
  - typedef req_vec_t (logic [15:0]), idx_t (logic [3:0])
  - enum arb_state_t {IDLE, BUSY}
- Sub-module decoder_4_16:
  - Combinational: idx_t in, enable in, 16-bit one-hot out, all-zero when disabled.
  - Instantiated once to drive grant.
- Rotating priority search: a function in arb_pkg, first_set_from(req, ptr), returning a valid flag and idx_t.

Test Plan:
- Reset, then req=16'h0001 with enable=1 -> next cycle grant_valid=1, grant_idx=0, grant=16'h0001, preempt=0.
- Round-robin check:
  - req=16'h8001 held, requester 0 drops at cycle 3 -> grant=0 for one cycle.
  - Then grant_idx=15, grant=16'h8000.
  - On its release, ptr wraps to 0 and the next grant is idx 0.
- Preemption, MAX_HOLD=8:
  - req[5] held continuously, req[9] raised at grant cycle 2.
  - After 8 grant cycles -> preempt pulses once, grant=0 for one cycle, then grant_idx=9.
- Sole requester, MAX_HOLD=8: req[3] held for 40 cycles with no other req -> grant stays 16'h0008 throughout; preempt never asserts.
- enable gating:
  - enable=0 with req=16'hFFFF -> grant stays 0.
  - Set enable=1 -> grant=16'h0001 on the next cycle.
  - Drop enable during the grant -> grant persists until req[0] falls.
- Async reset:
  - Assert rst_n=0 mid-grant between clock edges -> grant, grant_valid and grant_idx clear immediately.
  - After release with req=16'h0010 -> grant_idx=4 (search restarts from ptr=0).
